uart_rx_aux: RTL and testbench

- 16x-oversampled UART receiver for the auxiliary UART path.
- Consumes the one-clock `ticks` strobe from the auxiliary baud-rate generator. At 100 MHz / 9600 baud that is one tick every 651 clocks, so 16 ticks make one bit period.
- Deserialises an 8N1 frame, LSB first, from the asynchronous `rx` pin.
- Presents the received byte to the downstream FIFO or decoder with a one-cycle `rx_done` strobe.

---
 rtl/uart_rx_aux.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_aux.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_aux.sv
// 16x-oversampled 8N1 UART receiver for the auxiliary UART path.
// Optional even-parity check is enabled by defining UART_RX_AUX_PARITY_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle; watching rx_s for a falling start edge every clock
// START  | counting to mid start bit to reject glitches
// DATA   | sampling data bits, LSB first, at each bit centre
// PARITY | sampling the parity bit (only with UART_RX_AUX_PARITY_EN)
// STOP   | sampling the stop bit; delivers the word at window end
module uart_rx_aux #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ticks,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err
);

`ifdef UART_RX_AUX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [4:0] S_MID   = 5'd7;
  localparam logic [4:0] S_LAST  = 5'd15;
  localparam logic [4:0] SB_LAST = 5'(SB_TICKS - 1);
  localparam logic [2:0] N_LAST  = 3'(DATA_BITS - 1);

  state_t               state, state_next;
  logic [4:0]           s, s_next;
  logic [2:0]           n, n_next;
  logic [DATA_BITS-1:0] b, b_next;
  logic                 rx_meta, rx_s;
  logic                 done_set;
`ifdef UART_RX_AUX_PARITY_EN
  logic                 par_set;
  logic                 par_flag;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    case (state)
      IDLE: begin
        // start detect runs every clock, not only on ticks
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (ticks) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (ticks) begin
          if (s == S_LAST) begin
            s_next = '0;
            b_next = {rx_s, b[DATA_BITS-1:1]};
            if (n == N_LAST) begin
`ifdef UART_RX_AUX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
`ifdef UART_RX_AUX_PARITY_EN
      PARITY: begin
        if (ticks) begin
          if (s == S_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (ticks) begin
          if (s == SB_LAST) begin
            state_next = IDLE;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_set = ticks && (state == STOP) && (s == SB_LAST);
`ifdef UART_RX_AUX_PARITY_EN
    par_set  = ticks && (state == PARITY) && (s == S_LAST);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= done_set;
      if (done_set) begin
        rx_data   <= b;
        frame_err <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_AUX_PARITY_EN
  // parity is judged when sampled but only published alongside rx_done
  always_ff @(posedge clock) begin
    if (reset) begin
      par_flag   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_set)
        par_flag <= (^b) ^ rx_s;
      if (done_set)
        parity_err <= par_flag;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_aux.sv
// Randomized self-checking bench for uart_rx_aux against a frame-level scoreboard.
// Define UART_RX_AUX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_uart_rx_aux;
  logic       clock;
  logic       reset;
  logic       ticks;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_data;
  logic       last_ferr;
  logic       last_perr;
  logic       prev_done;
  int         checks;
  int         errors;
  int         done_count;
  int         tick_div;
  int         tcnt;

  uart_rx_aux #(.DATA_BITS(8), .SB_TICKS(16)) dut (
    .clock(clock),
    .reset(reset),
    .ticks(ticks),
    .rx(rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // tick strobe; tick_div = 1 gives ticks on every clock
  initial begin
    ticks = 1'b0;
    tcnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      if (tcnt >= tick_div - 1) begin
        tcnt  = 0;
        ticks = 1'b1;
      end else begin
        tcnt  = tcnt + 1;
        ticks = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // per-cycle compare against the scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_done) begin
        done_count++;
        chk("done_width", {31'd0, prev_done}, 32'd0);
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got rx_done=1 data %0h expected no frame", rx_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          last_data = e.data;
          last_ferr = e.ferr;
          last_perr = e.perr;
        end
      end else begin
        chk("hold", {22'd0, rx_data, frame_err, parity_err},
            {22'd0, last_data, last_ferr, last_perr});
      end
      prev_done = rx_done;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // drive one frame; bad stop bit is held low for 3/4 bit then an extra idle bit follows
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pbit,
                            input int gap_bits);
    int   bitlen;
    exp_t e;
    bitlen = 16 * tick_div;
    e.data = d;
    e.ferr = !stop_ok;
`ifdef UART_RX_AUX_PARITY_EN
    e.perr = (^d) ^ pbit;
`else
    e.perr = 1'b0;
`endif
    q.push_back(e);
    rx = 1'b0;
    clks(bitlen);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clks(bitlen);
    end
`ifdef UART_RX_AUX_PARITY_EN
    rx = pbit;
    clks(bitlen);
`endif
    if (stop_ok) begin
      rx = 1'b1;
      clks(bitlen);
    end else begin
      rx = 1'b0;
      clks(bitlen * 3 / 4);
      rx = 1'b1;
      clks(bitlen / 4 + bitlen);
    end
    chk("done_timely", q.size(), 0);
    q.delete();
    if (gap_bits > 0) clks(gap_bits * bitlen);
  endtask

  initial begin
    int dc;
    logic [7:0] d;
    bit ok;
    checks     = 0;
    errors     = 0;
    done_count = 0;
    prev_done  = 1'b0;
    last_data  = 8'h00;
    last_ferr  = 1'b0;
    last_perr  = 1'b0;
    tick_div   = 4;
    rx         = 1'b1;
    reset      = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(2);
    chk("reset_data", {24'd0, rx_data}, 32'h0);
    chk("reset_done", {31'd0, rx_done}, 32'h0);
    chk("reset_ferr", {31'd0, frame_err}, 32'h0);
    chk("reset_perr", {31'd0, parity_err}, 32'h0);
    clks(20);

    dc = done_count;
    send_frame(8'h55, 1, ^8'h55, 1);
    chk("f55_count", done_count - dc, 1);
    chk("f55_data", {24'd0, rx_data}, 32'h55);
    chk("f55_ferr", {31'd0, frame_err}, 32'h0);

    dc = done_count;
    send_frame(8'hA3, 1, ^8'hA3, 0);
    send_frame(8'h0F, 1, ^8'h0F, 1);
    chk("b2b_count", done_count - dc, 2);
    chk("b2b_data", {24'd0, rx_data}, 32'h0F);

    dc = done_count;
    rx = 1'b0;
    clks(4 * tick_div);
    rx = 1'b1;
    clks(32 * tick_div);
    chk("glitch_count", done_count - dc, 0);
    chk("glitch_data", {24'd0, rx_data}, 32'h0F);

    send_frame(8'hFF, 0, ^8'hFF, 1);
    chk("ff_data", {24'd0, rx_data}, 32'hFF);
    chk("ff_ferr", {31'd0, frame_err}, 32'h1);
    send_frame(8'h12, 1, ^8'h12, 1);
    chk("f12_ferr", {31'd0, frame_err}, 32'h0);

    // reset pulse in the middle of data bit 4 of 0x3C; transmitter aborts too
    dc = done_count;
    d  = 8'h3C;
    rx = 1'b0;
    clks(64);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      clks(64);
    end
    rx = d[4];
    clks(32);
    reset = 1'b1;
    q.delete();
    last_data = 8'h00;
    last_ferr = 1'b0;
    last_perr = 1'b0;
    clks(1);
    reset = 1'b0;
    rx    = 1'b1;
    clks(128);
    chk("rst_count", done_count - dc, 0);
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    send_frame(8'h3C, 1, ^8'h3C, 1);
    chk("f3c_data", {24'd0, rx_data}, 32'h3C);

`ifdef UART_RX_AUX_PARITY_EN
    send_frame(8'h07, 1, 1'b1, 1);
    chk("par_ok_data", {24'd0, rx_data}, 32'h07);
    chk("par_ok", {31'd0, parity_err}, 32'h0);
    send_frame(8'h07, 1, 1'b0, 1);
    chk("par_bad_data", {24'd0, rx_data}, 32'h07);
    chk("par_bad", {31'd0, parity_err}, 32'h1);
`endif

    for (int k = 0; k < 25; k++) begin
      tick_div = $urandom_range(1, 5);
      clks(32 * tick_div);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(8'($urandom), ok, 1'($urandom), $urandom_range(0, 2));
    end

    clks(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
